// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes sources, latches pending bits,
// masks, picks a fixed-priority winner and hands it to the CPU as one-hot HWInt.
module irq_ctrl #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [29:0]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic            int_taken,
    output logic [NSRC-1:0] HWInt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [NSRC-1:0] sync_r [SYNC_STAGES];
    logic [NSRC-1:0] s_s;
    logic [NSRC-1:0] s_d_r;
    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] pend_nx_s;
    logic [NSRC-1:0] mask_r;
    logic [NSRC-1:0] edge_r;
    logic [NSRC-1:0] hwint_r;
    logic [NSRC-1:0] hwint_nx_s;
    logic [NSRC-1:0] req_vec_s;
    logic [NSRC-1:0] winner_s;
    logic [NSRC-1:0] acc_clr_s;
    logic [2:0]      isr_id_r;
    logic [2:0]      isr_id_nx_s;
    state_t          state_r;
    state_t          state_nx_s;
    logic            req_s;
    logic            wr_pend_s;
    logic            wr_mask_s;
    logic            wr_edge_s;
    logic            wr_vect_s;
    logic            unused_s;

    // Isolate the lowest set bit: lowest index wins.
    function automatic logic [NSRC-1:0] lowest_onehot(input logic [NSRC-1:0] v);
        lowest_onehot = v & (~v + {{(NSRC-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [2:0] onehot_to_id(input logic [NSRC-1:0] v);
        onehot_to_id = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) begin
                onehot_to_id = i[2:0];
            end else begin
                onehot_to_id = onehot_to_id;
            end
        end
    endfunction

    assign s_s       = sync_r[SYNC_STAGES-1];
    assign rise_s    = s_s & ~s_d_r;
    assign req_vec_s = pend_r & mask_r;
    assign req_s     = |req_vec_s;
    assign winner_s  = lowest_onehot(req_vec_s);
    assign wr_pend_s = WE && (Addr[1:0] == 2'd0);
    assign wr_mask_s = WE && (Addr[1:0] == 2'd1);
    assign wr_edge_s = WE && (Addr[1:0] == 2'd2);
    assign wr_vect_s = WE && (Addr[1:0] == 2'd3);
    assign HWInt     = hwint_r;
    assign unused_s  = ^{Addr[29:2], Din[31:NSRC]};

    // Source synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {NSRC{1'b0}};
            end
            s_d_r <= {NSRC{1'b0}};
        end else begin
            sync_r[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            s_d_r <= s_s;
        end
    end

    // Pending-bit update: level bits track the source, edge bits latch (set beats clear).
    always_comb begin
        pend_nx_s = pend_r;
        for (int i = 0; i < NSRC; i++) begin
            if (wr_edge_s && (Din[i] != edge_r[i])) begin
                pend_nx_s[i] = 1'b0;
            end else if (!edge_r[i]) begin
                pend_nx_s[i] = s_s[i];
            end else if (rise_s[i]) begin
                pend_nx_s[i] = 1'b1;
            end else if ((wr_pend_s && Din[i]) || acc_clr_s[i]) begin
                pend_nx_s[i] = 1'b0;
            end else begin
                pend_nx_s[i] = pend_r[i];
            end
        end
    end

    // Next-state and request logic for the CPU handshake.
    always_comb begin
        state_nx_s  = state_r;
        hwint_nx_s  = hwint_r;
        isr_id_nx_s = isr_id_r;
        acc_clr_s   = {NSRC{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nx_s = ST_ASSERT;
                    hwint_nx_s = winner_s;
                end else begin
                    hwint_nx_s = {NSRC{1'b0}};
                end
            end
            ST_ASSERT: begin
                if (!req_s) begin
                    state_nx_s = ST_IDLE;
                    hwint_nx_s = {NSRC{1'b0}};
                end else if (int_taken) begin
                    // Acknowledge the source the CPU actually saw, not a late arrival.
                    state_nx_s  = ST_SERVICE;
                    isr_id_nx_s = onehot_to_id(hwint_r);
                    acc_clr_s   = hwint_r & edge_r;
                    hwint_nx_s  = {NSRC{1'b0}};
                end else begin
                    hwint_nx_s = winner_s;
                end
            end
            ST_SERVICE: begin
                hwint_nx_s = {NSRC{1'b0}};
                if (wr_vect_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SERVICE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                hwint_nx_s = {NSRC{1'b0}};
            end
        endcase
    end

    // Control/status registers, FSM state and the registered request output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r   <= {NSRC{1'b0}};
            mask_r   <= {NSRC{1'b1}};
            edge_r   <= {NSRC{1'b0}};
            hwint_r  <= {NSRC{1'b0}};
            isr_id_r <= 3'd0;
            state_r  <= ST_IDLE;
        end else begin
            pend_r   <= pend_nx_s;
            hwint_r  <= hwint_nx_s;
            isr_id_r <= isr_id_nx_s;
            state_r  <= state_nx_s;
            if (wr_mask_s) begin
                mask_r <= Din[NSRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_edge_s) begin
                edge_r <= Din[NSRC-1:0];
            end else begin
                edge_r <= edge_r;
            end
        end
    end

    // Read mux; unused upper bits read as zero.
    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd0:    Dout = {{(32-NSRC){1'b0}}, pend_r};
            2'd1:    Dout = {{(32-NSRC){1'b0}}, mask_r};
            2'd2:    Dout = {{(32-NSRC){1'b0}}, edge_r};
            2'd3:    Dout = {(state_r != ST_IDLE), 26'd0, state_r, isr_id_r};
            default: Dout = 32'd0;
        endcase
    end

endmodule
